seg_display_formatter: RTL and testbench



---
 rtl/seg_display_formatter.sv | 121 ++++++++++++
 tb/tb_seg_display_formatter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_formatter.sv
// seg_display_formatter: binary-to-BCD double-dabble with 7-segment encoding, leading-zero blanking and edit-blink timer
module seg_display_formatter #(
    parameter int FLASH_HALF = 25_000_000,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        load,
    input  logic        edit_mode,
    input  logic [1:0]  edit_pos,
    output logic [6:0]  digit1,
    output logic [6:0]  digit2,
    output logic [6:0]  digit3,
    output logic [6:0]  digit4,
    output logic        flash,
    output logic [1:0]  an_toflash,
    output logic        busy,
    output logic        overflow
);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam int CW = FLASH_HALF > 1 ? $clog2(FLASH_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

    state_t        state;
    logic [13:0]   bin;
    logic [15:0]   bcd;
    logic [15:0]   adj;
    logic [3:0]    cnt;
    logic          ovf;
    logic          z3, z2, z1;
    logic [CW-1:0] fcnt;
    logic          phase;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = BLANK;
        endcase
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // blanking cascades from the left: a digit blanks only if all digits to its left are blank too
    assign z3 = LZ_BLANK && bcd[15:12] == 4'd0;
    assign z2 = z3 && bcd[11:8] == 4'd0;
    assign z1 = z2 && bcd[7:4] == 4'd0;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            digit1   <= BLANK;
            digit2   <= BLANK;
            digit3   <= BLANK;
            digit4   <= BLANK;
        end else begin
            case (state)
                IDLE: if (load) begin
                    bin   <= value;
                    bcd   <= '0;
                    cnt   <= '0;
                    ovf   <= value > 14'd9999;
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= {adj, bin} << 1;
                    cnt        <= cnt + 4'd1;
                    if (cnt == 4'd13) state <= ENCODE;
                end
                ENCODE: begin
                    digit1   <= ovf ? DASH : z3 ? BLANK : seg7(bcd[15:12]);
                    digit2   <= ovf ? DASH : z2 ? BLANK : seg7(bcd[11:8]);
                    digit3   <= ovf ? DASH : z1 ? BLANK : seg7(bcd[7:4]);
                    digit4   <= ovf ? DASH : seg7(bcd[3:0]);
                    overflow <= ovf;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // flash follows phase one cycle late so the first blink lands FLASH_HALF cycles after enable
    always_ff @(posedge clk_in) begin
        if (reset || !edit_mode) begin
            fcnt  <= '0;
            phase <= 1'b0;
            flash <= 1'b0;
        end else begin
            fcnt  <= fcnt == LAST ? '0 : fcnt + CW'(1);
            phase <= phase ^ (fcnt == LAST);
            flash <= phase;
        end
    end

    always_ff @(posedge clk_in) begin
        an_toflash <= reset ? 2'd0 : edit_pos;
    end
endmodule

// File: tb/tb_seg_display_formatter.sv
// tb_seg_display_formatter: scoreboard bench for both blanking variants of seg_display_formatter
module tb_seg_display_formatter;
    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        edit_mode = 1'b0;
    logic [13:0] value = '0;
    logic [1:0]  edit_pos = '0;
    logic [6:0]  d1, d2, d3, d4, n1, n2, n3, n4;
    logic        flash, nflash, busy, nbusy, ovf, novf;
    logic [1:0]  an, nan;

    always #5 clk_in = ~clk_in;

    seg_display_formatter #(.FLASH_HALF(4), .LZ_BLANK(1'b1)) u_lz (
        .clk_in(clk_in), .reset(reset), .value(value), .load(load),
        .edit_mode(edit_mode), .edit_pos(edit_pos),
        .digit1(d1), .digit2(d2), .digit3(d3), .digit4(d4),
        .flash(flash), .an_toflash(an), .busy(busy), .overflow(ovf));

    seg_display_formatter #(.FLASH_HALF(4), .LZ_BLANK(1'b0)) u_nz (
        .clk_in(clk_in), .reset(reset), .value(value), .load(load),
        .edit_mode(edit_mode), .edit_pos(edit_pos),
        .digit1(n1), .digit2(n2), .digit3(n3), .digit4(n4),
        .flash(nflash), .an_toflash(nan), .busy(nbusy), .overflow(novf));

    typedef struct {
        logic [27:0] l;
        logic [27:0] n;
        logic        ov;
        int          len;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          compared = 0;
    int          mismatched = 0;
    logic [27:0] cur_l = {4{7'h7f}};
    logic [27:0] cur_n = {4{7'h7f}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] pat(input string s);
        logic [6:0]  seg [10];
        logic [27:0] r;
        byte         c;
        seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        r = '0;
        for (int i = 0; i < 4; i++) begin
            c = s[i];
            r = {r[20:0], c == " " ? 7'h7f : c == "-" ? 7'h3f : seg[int'(c) - 48]};
        end
        return r;
    endfunction

    // monitor: digits must hold while busy; each busy fall retires one scoreboard entry
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk_in);
            if (busy) begin
                run++;
                check("hold_lz", 32'({d1, d2, d3, d4}), 32'(cur_l));
                check("hold_nz", 32'({n1, n2, n3, n4}), 32'(cur_n));
            end else if (run > 0) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(run), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("digits_lz", 32'({d1, d2, d3, d4}), 32'(e.l));
                    check("digits_nz", 32'({n1, n2, n3, n4}), 32'(e.n));
                    check("overflow", 32'(ovf), 32'(e.ov));
                    check("overflow_nz", 32'(novf), 32'(e.ov));
                    check("busy_len", 32'(run), 32'(e.len));
                    cur_l = e.l;
                    cur_n = e.n;
                end
                run = 0;
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 60) begin
            @(negedge clk_in);
            t++;
        end
        if (t >= 60) check("busy_timeout", 32'(t), 32'(0));
        @(negedge clk_in);
    endtask

    task automatic start(input logic [13:0] v, input string lz, input string nz, input logic ov, input int len);
        q.push_back('{pat(lz), pat(nz), ov, len});
        value = v;
        load = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
    endtask

    task automatic do_load(input logic [13:0] v, input string lz, input string nz, input logic ov);
        start(v, lz, nz, ov, 15);
        wait_idle();
    endtask

    initial begin
        logic [15:0] fp;
        fp = 16'b0000111100001111;
        repeat (3) @(negedge clk_in);
        check("rst_digits", 32'({d1, d2, d3, d4}), 32'({4{7'h7f}}));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_overflow", 32'(ovf), 32'(0));
        check("rst_flash", 32'(flash), 32'(0));
        check("rst_an", 32'(an), 32'(0));
        reset = 1'b0;
        @(negedge clk_in);
        do_load(14'd1234, "1234", "1234", 1'b0);
        do_load(14'd7, "   7", "0007", 1'b0);
        do_load(14'd0, "   0", "0000", 1'b0);
        do_load(14'd10000, "----", "----", 1'b1);
        do_load(14'd42, "  42", "0042", 1'b0);
        do_load(14'd305, " 305", "0305", 1'b0);
        start(14'd5678, "5678", "5678", 1'b0, 15);
        repeat (4) @(negedge clk_in);
        value = 14'd1111;
        load = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
        wait_idle();
        do_load(14'd9999, "9999", "9999", 1'b0);
        do_load(14'd1, "   1", "0001", 1'b0);
        start(14'd4021, "    ", "    ", 1'b0, 8);
        repeat (7) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        wait_idle();
        do_load(14'd800, " 800", "0800", 1'b0);
        edit_pos = 2'd2;
        edit_mode = 1'b1;
        fork
            do_load(14'd56, "  56", "0056", 1'b0);
            begin
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk_in);
                    if (k == 0) check("an_toflash", 32'(an), 32'(2));
                    check($sformatf("flash_%0d", k), 32'(flash), 32'(fp[15 - k]));
                end
            end
        join
        edit_mode = 1'b0;
        repeat (2) begin
            @(negedge clk_in);
            check("flash_drop", 32'(flash), 32'(0));
        end
        edit_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            check($sformatf("flash_re_%0d", k), 32'(flash), 32'(fp[15 - k]));
        end
        edit_mode = 1'b0;
        repeat (3) @(negedge clk_in);
        check("queue_drained", 32'(q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
